// File: rtl/wctl_barrier_ctrl.sv
// Local warp-barrier controller.
// Tracks which warps have arrived at each barrier ID. Once the last participant arrives it
// raises a one-deep release towards the warp scheduler. It also exports a stall mask that
// keeps waiting warps out of issue until their release has been handed off.
module wctl_barrier_ctrl #(
  parameter int unsigned NUM_WARPS    = 4,
  parameter int unsigned NUM_BARRIERS = 4,
  parameter int unsigned NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int unsigned NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bar_valid,
  output logic                 bar_ready,
  input  logic [NW_WIDTH-1:0]  bar_wid,
  input  logic [NB_WIDTH-1:0]  bar_id,
  input  logic [NW_WIDTH-1:0]  bar_size_m1,
  input  logic                 bar_is_noop,
  input  logic                 exit_valid,
  input  logic [NW_WIDTH-1:0]  exit_wid,
  output logic                 rel_valid,
  input  logic                 rel_ready,
  output logic [NUM_WARPS-1:0] rel_wmask,
  output logic [NUM_WARPS-1:0] stall_mask
);

  typedef logic [NUM_WARPS-1:0] wmask_t;
  typedef logic [NW_WIDTH-1:0]  cnt_t;

  localparam wmask_t WarpOne = wmask_t'(1);
  localparam cnt_t   CntOne  = cnt_t'(1);

  // Per-barrier arrival state.
  wmask_t wait_mask_q [NUM_BARRIERS];
  wmask_t wait_mask_d [NUM_BARRIERS];
  cnt_t   count_q     [NUM_BARRIERS];
  cnt_t   count_d     [NUM_BARRIERS];

  // Single release register towards the scheduler.
  logic   rel_valid_q, rel_valid_d;
  wmask_t rel_wmask_q, rel_wmask_d;

  // Barrier state after this cycle's exit has been applied.
  wmask_t post_mask  [NUM_BARRIERS];
  cnt_t   post_count [NUM_BARRIERS];

  wmask_t arr_bit;
  wmask_t exit_bit;
  wmask_t sel_mask;
  cnt_t   sel_count;
  logic   accept;
  logic   arr_drop;
  logic   arr_live;
  logic   arr_dup;
  logic   arr_done;

  assign arr_bit  = WarpOne << bar_wid;
  assign exit_bit = WarpOne << exit_wid;

  // Arrivals stall only behind a release the scheduler has not yet taken.
  assign bar_ready = ~reset & ~(rel_valid_q & ~rel_ready);
  assign accept    = bar_valid & bar_ready;
  // A warp exiting in the same cycle as its own arrival never joins the barrier.
  assign arr_drop  = exit_valid & (exit_wid == bar_wid);
  assign arr_live  = accept & ~arr_drop;

  assign sel_mask  = post_mask[bar_id];
  assign sel_count = post_count[bar_id];
  assign arr_dup   = (wait_mask_q[bar_id] & arr_bit) != '0;
  // Completion uses the post-exit count so a leaving warp does not count towards the quorum.
  assign arr_done  = (sel_count == bar_size_m1);

  // Remove an exiting warp from every barrier it is waiting on; exits never release.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
      post_mask[b]  = wait_mask_q[b];
      post_count[b] = count_q[b];
      if (exit_valid && ((wait_mask_q[b] & exit_bit) != '0)) begin
        post_mask[b]  = wait_mask_q[b] & ~exit_bit;
        post_count[b] = count_q[b] - CntOne;
      end
    end
  end

  // Next-state for barrier tracking and the release register.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
      wait_mask_d[b] = post_mask[b];
      count_d[b]     = post_count[b];
    end
    rel_valid_d = rel_valid_q;
    rel_wmask_d = rel_wmask_q;

    if (rel_valid_q && rel_ready) begin
      rel_valid_d = 1'b0;
    end

    if (arr_live) begin
      if (bar_is_noop) begin
        rel_valid_d = 1'b1;
        rel_wmask_d = arr_bit;
      end else if (!arr_dup) begin
        if (arr_done) begin
          rel_valid_d         = 1'b1;
          rel_wmask_d         = sel_mask | arr_bit;
          wait_mask_d[bar_id] = '0;
          count_d[bar_id]     = '0;
        end else begin
          wait_mask_d[bar_id] = sel_mask | arr_bit;
          count_d[bar_id]     = sel_count + CntOne;
        end
      end
    end
  end

  // State registers; reset discards every wait and any pending release.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
        wait_mask_q[b] <= '0;
        count_q[b]     <= '0;
      end
      rel_valid_q <= 1'b0;
      rel_wmask_q <= '0;
    end else begin
      for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
        wait_mask_q[b] <= wait_mask_d[b];
        count_q[b]     <= count_d[b];
      end
      rel_valid_q <= rel_valid_d;
      rel_wmask_q <= rel_wmask_d;
    end
  end

  // Warps stay stalled while waiting and until their release handshake completes.
  always_comb begin
    stall_mask = rel_valid_q ? rel_wmask_q : '0;
    for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
      stall_mask = stall_mask | wait_mask_q[b];
    end
  end

  assign rel_valid = rel_valid_q;
  assign rel_wmask = rel_wmask_q;

  // A warp arriving twice at the same barrier indicates a broken commit path.
  a_no_dup_arrival: assert property (@(posedge clk) disable iff (reset)
    (arr_live && !bar_is_noop) |-> !arr_dup);

  // Barrier sizes beyond the warp count can never complete.
  a_size_in_range: assert property (@(posedge clk) disable iff (reset)
    (accept && !bar_is_noop) |-> (32'(bar_size_m1) < NUM_WARPS));

endmodule

// File: tb/tb_wctl_barrier_ctrl.sv
// Directed bench for wctl_barrier_ctrl with a set-based reference model checked every cycle.
module tb_wctl_barrier_ctrl;

  localparam int NW = 4;
  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       bar_valid;
  logic       bar_ready;
  logic [1:0] bar_wid;
  logic [1:0] bar_id;
  logic [1:0] bar_size_m1;
  logic       bar_is_noop;
  logic       exit_valid;
  logic [1:0] exit_wid;
  logic       rel_valid;
  logic       rel_ready;
  logic [3:0] rel_wmask;
  logic [3:0] stall_mask;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Reference model: set of arrived warps per barrier, plus one pending release.
  bit       m_arr [NB][NW];
  bit       m_pend;
  bit [3:0] m_mask;

  wctl_barrier_ctrl #(
    .NUM_WARPS    (NW),
    .NUM_BARRIERS (NB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bar_valid   (bar_valid),
    .bar_ready   (bar_ready),
    .bar_wid     (bar_wid),
    .bar_id      (bar_id),
    .bar_size_m1 (bar_size_m1),
    .bar_is_noop (bar_is_noop),
    .exit_valid  (exit_valid),
    .exit_wid    (exit_wid),
    .rel_valid   (rel_valid),
    .rel_ready   (rel_ready),
    .rel_wmask   (rel_wmask),
    .stall_mask  (stall_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_stall();
    logic [3:0] s;
    s = m_pend ? m_mask : 4'b0000;
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < NW; w++)
        if (m_arr[b][w]) s[w] = 1'b1;
    return s;
  endfunction

  // Apply one clock edge of the barrier rules to the model.
  task automatic model_step();
    bit [3:0] nmask;
    bit       nrel;
    bit       hs;
    bit       rdy;
    int       id;
    int       w;
    int       n;
    if (reset) begin
      for (int b = 0; b < NB; b++)
        for (int i = 0; i < NW; i++) m_arr[b][i] = 1'b0;
      m_pend = 1'b0;
      m_mask = 4'b0000;
      return;
    end
    rdy   = !(m_pend && !rel_ready);
    hs    = m_pend && rel_ready;
    nrel  = 1'b0;
    nmask = 4'b0000;
    if (exit_valid)
      for (int b = 0; b < NB; b++) m_arr[b][int'(exit_wid)] = 1'b0;
    if (bar_valid && rdy && !(exit_valid && exit_wid == bar_wid)) begin
      w = int'(bar_wid);
      id = int'(bar_id);
      if (bar_is_noop) begin
        nrel = 1'b1;
        nmask[w] = 1'b1;
      end else if (!m_arr[id][w]) begin
        n = 0;
        for (int i = 0; i < NW; i++) n += int'(m_arr[id][i]);
        if (n == int'(bar_size_m1)) begin
          nrel = 1'b1;
          for (int i = 0; i < NW; i++) nmask[i] = m_arr[id][i];
          nmask[w] = 1'b1;
          for (int i = 0; i < NW; i++) m_arr[id][i] = 1'b0;
        end else begin
          m_arr[id][w] = 1'b1;
        end
      end
    end
    if (nrel) begin
      m_pend = 1'b1;
      m_mask = nmask;
    end else if (hs) begin
      m_pend = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        check("m_bar_ready", 32'(bar_ready), 32'(!reset && !(m_pend && !rel_ready)));
        check("m_rel_valid", 32'(rel_valid), 32'(m_pend));
        if (m_pend) check("m_rel_wmask", 32'(rel_wmask), 32'(m_mask));
        check("m_stall_mask", 32'(stall_mask), 32'(model_stall()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arrive(input logic [1:0] w, input logic [1:0] id, input logic [1:0] sm1,
                        input logic noop);
    bar_valid   = 1'b1;
    bar_wid     = w;
    bar_id      = id;
    bar_size_m1 = sm1;
    bar_is_noop = noop;
    step();
    bar_valid   = 1'b0;
    bar_is_noop = 1'b0;
  endtask

  task automatic do_exit(input logic [1:0] w);
    exit_valid = 1'b1;
    exit_wid   = w;
    step();
    exit_valid = 1'b0;
  endtask

  task automatic arrive_exit(input logic [1:0] w, input logic [1:0] id, input logic [1:0] sm1,
                             input logic [1:0] ew);
    exit_valid = 1'b1;
    exit_wid   = ew;
    arrive(w, id, sm1, 1'b0);
    exit_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic rv, input logic [3:0] wm,
                            input logic [3:0] sm);
    check({tag, "_rel_valid"}, 32'(rel_valid), 32'(rv));
    if (rv) check({tag, "_rel_wmask"}, 32'(rel_wmask), 32'(wm));
    check({tag, "_stall"}, 32'(stall_mask), 32'(sm));
  endtask

  initial begin
    reset       = 1'b1;
    bar_valid   = 1'b0;
    bar_wid     = 2'd0;
    bar_id      = 2'd0;
    bar_size_m1 = 2'd0;
    bar_is_noop = 1'b0;
    exit_valid  = 1'b0;
    exit_wid    = 2'd0;
    rel_ready   = 1'b1;
    step();
    check_en = 1'b1;
    step();
    check("rst_rel_valid", 32'(rel_valid), 32'd0);
    check("rst_rel_wmask", 32'(rel_wmask), 32'd0);
    check("rst_stall", 32'(stall_mask), 32'd0);
    check("rst_bar_ready", 32'(bar_ready), 32'd0);
    reset = 1'b0;
    step();

    // 1: three-warp barrier on id 1.
    arrive(2'd0, 2'd1, 2'd2, 1'b0);
    expect_out("t1a", 1'b0, 4'b0000, 4'b0001);
    arrive(2'd2, 2'd1, 2'd2, 1'b0);
    expect_out("t1b", 1'b0, 4'b0000, 4'b0101);
    arrive(2'd3, 2'd1, 2'd2, 1'b0);
    expect_out("t1c", 1'b1, 4'b1101, 4'b1101);
    step();
    expect_out("t1d", 1'b0, 4'b0000, 4'b0000);

    // 2: noop barrier releases only the arriving warp.
    arrive(2'd1, 2'd0, 2'd0, 1'b1);
    expect_out("t2a", 1'b1, 4'b0010, 4'b0010);
    step();
    expect_out("t2b", 1'b0, 4'b0000, 4'b0000);

    // 3: stalled release back-pressures arrivals.
    rel_ready = 1'b0;
    arrive(2'd2, 2'd0, 2'd0, 1'b1);
    bar_valid   = 1'b1;
    bar_wid     = 2'd0;
    bar_id      = 2'd3;
    bar_size_m1 = 2'd1;
    #1;
    check("t3_bar_ready_low", 32'(bar_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("t3_hold", 1'b1, 4'b0100, 4'b0100);
    end
    bar_valid = 1'b0;
    rel_ready = 1'b1;
    step();
    expect_out("t3_drop", 1'b0, 4'b0000, 4'b0000);
    #1;
    check("t3_bar_ready_high", 32'(bar_ready), 32'd1);

    // 4: exit removes a waiting warp without releasing.
    arrive(2'd0, 2'd2, 2'd1, 1'b0);
    expect_out("t4a", 1'b0, 4'b0000, 4'b0001);
    do_exit(2'd0);
    expect_out("t4b", 1'b0, 4'b0000, 4'b0000);
    arrive(2'd1, 2'd2, 2'd1, 1'b0);
    expect_out("t4c", 1'b0, 4'b0000, 4'b0010);
    arrive(2'd3, 2'd2, 2'd1, 1'b0);
    expect_out("t4d", 1'b1, 4'b1010, 4'b1010);
    step();

    // 5: interleaved barriers, back-to-back releases.
    arrive(2'd0, 2'd0, 2'd1, 1'b0);
    arrive(2'd1, 2'd3, 2'd1, 1'b0);
    expect_out("t5a", 1'b0, 4'b0000, 4'b0011);
    arrive(2'd2, 2'd0, 2'd1, 1'b0);
    expect_out("t5b", 1'b1, 4'b0101, 4'b0111);
    arrive(2'd3, 2'd3, 2'd1, 1'b0);
    expect_out("t5c", 1'b1, 4'b1010, 4'b1010);
    step();
    expect_out("t5d", 1'b0, 4'b0000, 4'b0000);

    // 6: reset mid-operation.
    arrive(2'd0, 2'd1, 2'd3, 1'b0);
    arrive(2'd1, 2'd1, 2'd3, 1'b0);
    rel_ready = 1'b0;
    arrive(2'd3, 2'd0, 2'd0, 1'b1);
    expect_out("t6a", 1'b1, 4'b1000, 4'b1011);
    reset = 1'b1;
    step();
    check("t6_rel_valid", 32'(rel_valid), 32'd0);
    check("t6_rel_wmask", 32'(rel_wmask), 32'd0);
    check("t6_stall", 32'(stall_mask), 32'd0);
    check("t6_bar_ready", 32'(bar_ready), 32'd0);
    reset = 1'b0;
    rel_ready = 1'b1;
    arrive(2'd2, 2'd1, 2'd1, 1'b0);
    expect_out("t6b", 1'b0, 4'b0000, 4'b0100);
    do_exit(2'd2);
    expect_out("t6c", 1'b0, 4'b0000, 4'b0000);

    // 7: simultaneous exit and arrival.
    arrive(2'd0, 2'd2, 2'd1, 1'b0);
    arrive_exit(2'd1, 2'd2, 2'd1, 2'd0);
    expect_out("t7a", 1'b0, 4'b0000, 4'b0010);
    exit_valid  = 1'b1;
    exit_wid    = 2'd3;
    bar_valid   = 1'b1;
    bar_wid     = 2'd3;
    bar_id      = 2'd2;
    bar_size_m1 = 2'd1;
    #1;
    check("t7_bar_ready_drop", 32'(bar_ready), 32'd1);
    step();
    bar_valid  = 1'b0;
    exit_valid = 1'b0;
    expect_out("t7b", 1'b0, 4'b0000, 4'b0010);
    arrive(2'd3, 2'd2, 2'd1, 1'b0);
    expect_out("t7c", 1'b1, 4'b1010, 4'b1010);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wctl_barrier_ctrl.md
Name: wctl_barrier_ctrl

Overview:
- Local warp-barrier controller fed by barrier events from the warp-control commit path: one `{valid, id, size_m1, is_noop}` event per retired barrier instruction.
- Per barrier ID, tracks which warps have arrived and counts arrivals.
- When the last required warp arrives, emits a release mask to the warp scheduler over a valid/ready handshake.
- Exports a stall mask that holds arrived warps out of issue until they are released.

Parameters:
- NUM_WARPS, 4, warps per core; must be ≥2.
- NUM_BARRIERS, 4, barrier IDs per core; must be ≥1.
- NW_WIDTH, max(1,clog2(NUM_WARPS)), warp-ID width.
- NB_WIDTH, max(1,clog2(NUM_BARRIERS)), barrier-ID width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- bar_valid  in  1  barrier arrival event
- bar_ready  out  1  arrival accepted this cycle when high
- bar_wid  in  NW_WIDTH  arriving warp
- bar_id  in  NB_WIDTH  barrier ID
- bar_size_m1  in  NW_WIDTH  participating warps minus 1
- bar_is_noop  in  1  size==1 barrier; release arriving warp only
- exit_valid  in  1  warp terminated (tmc to zero mask)
- exit_wid  in  NW_WIDTH  terminated warp
- rel_valid  out  1  release pending
- rel_ready  in  1  scheduler accepts release
- rel_wmask  out  NUM_WARPS  warps to unstall
- stall_mask  out  NUM_WARPS  warps currently blocked on any barrier

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- Reset values:
  - All wait_mask[b] = 0 and count[b] = 0.
  - rel_valid = 0, rel_wmask = 0, stall_mask = 0.
  - bar_ready = 0 while reset is high.
- Accept rule: bar_ready = ~reset & ~(rel_valid & ~rel_ready). Arrivals are blocked only while a release is stalled. Accept = bar_valid & bar_ready.
- Accepted non-noop arrival for barrier b = bar_id, warp w, where w is not in wait_mask[b]:
  - If count[b] == bar_size_m1 (completing arrival): next cycle rel_valid = 1 and rel_wmask = wait_mask[b] | (1<<w). In the same edge, wait_mask[b] is cleared to 0 and count[b] to 0.
  - Otherwise: wait_mask[b] |= 1<<w, count[b] += 1.
- Duplicate arrival (w already in wait_mask[b]): no state change. Flag with a simulation assertion.
- Noop arrival: barrier state unchanged; next cycle rel_valid = 1 and rel_wmask = 1<<w.
- Release latency: exactly 1 cycle from the accepted completing or noop arrival to rel_valid. Only one release register exists.
- Release handshake:
  - rel_valid & rel_ready: release retires. rel_valid drops next cycle unless an arrival accepted in the same cycle produces a new release, in which case rel_wmask is reloaded back-to-back.
  - rel_valid & ~rel_ready: rel_valid and rel_wmask hold; bar_ready = 0.
- stall_mask (combinational from registers) = OR over b of wait_mask[b], OR (rel_valid ? rel_wmask : 0). A released warp stays stalled until its release handshake completes.
- Warp exit (exit_valid, warp e): for every b with e in wait_mask[b], clear that bit and decrement count[b]. The exit never triggers a release, even if the remaining count would now match.
- Simultaneous exit and arrival:
  - Same warp: the arrival is dropped, though bar_ready is still reported.
  - Different warps on the same barrier: the completion check uses count[b] minus the exiting warp's contribution.
- Width rule: count[b] never exceeds NUM_WARPS-1, so it is NW_WIDTH wide with no wrap. bar_size_m1 ≥ NUM_WARPS is an assertion error.
- Barriers are independent; only one arrival is processed per cycle.
- Reset mid-operation discards all waits and any pending release.

Test Plan (NUM_WARPS=4, NUM_BARRIERS=4):
1. size_m1=2 on id 1; arrivals w0, w2, w3 on consecutive cycles, rel_ready=1 → stall_mask 0001, 0101; the cycle after the w3 arrival, rel_valid=1 with rel_wmask=1101; stall_mask=0000 the cycle after the handshake.
2. Noop arrival w1 id 0 → next cycle rel_valid=1, rel_wmask=0010; wait_mask[0] and count[0] remain 0.
3. Hold rel_ready=0 with a pending release, drive bar_valid → bar_ready=0, rel_wmask stable for 5 cycles; assert rel_ready → rel_valid drops, then bar_ready=1.
4. size_m1=1 on id 2; w0 arrives, then w0 exits → count[2]=0, stall_mask=0000; arrivals w1, w3 → rel_wmask=1010.
5. Interleave ids 0 and 3, each size_m1=1, arrivals w0@id0, w1@id3, w2@id0, w3@id3 → two releases, 0101 then 1010, one cycle apart with rel_ready=1.
6. Reset asserted while wait_mask[1]=0011 and rel_valid=1 → next cycle all outputs 0; w2 arriving on id 1 with size_m1=1 does not release.
